// File: rtl/instruction_encoder_loader_if.sv
// Field-set handshake and instruction-memory write port of the encoder loader.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where the producer's valid (in_valid / mem_wr_en) and the consumer's ready
// (in_ready / mem_ready) are both high. The producer holds its payload stable
// while valid is high and ready is low.
interface instruction_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;

    // Environment side: supplies field sets, acts as the instruction memory.
    modport master (
        output in_valid, op, rs, rt, rd, imm, target, mem_ready,
        input  in_ready, mem_wr_en, mem_addr, mem_data
    );

    // Loader side.
    modport slave (
        input  in_valid, op, rs, rt, rd, imm, target, mem_ready,
        output in_ready, mem_wr_en, mem_addr, mem_data
    );
endinterface

// File: rtl/instruction_encoder_loader.sv
// Instruction encoder / loader: encodes one field set per transfer into a
// 32-bit instruction word and writes it to consecutive instruction-memory
// words starting at base_addr. One output register, pass-through ready.
// Optional macro ILLEGAL_OP_TRAP_EN: an illegal op stops the session in FULL
// instead of being written as a nop.
module instruction_encoder_loader (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [9:0]                    base_addr,
    input  logic                          finish,
    instruction_encoder_loader_if.slave   bus,
    output logic                          busy,
    output logic                          full,
    output logic [10:0]                   word_count,
    output logic [1:0]                    stateDbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_I   = 2'd0,
        KIND_R   = 2'd1,
        KIND_J   = 2'd2,
        KIND_NOP = 2'd3
    } kind_t;

    state_t      state;
    state_t      stateNext;
    kind_t       kind;
    logic [5:0]  code;
    logic [31:0] encWord;
    logic        accept;
    logic        trapHit;
    logic        writeNow;
    logic        lastAddr;
    logic        wrEn;
    logic [9:0]  addrReg;
    logic [31:0] dataReg;
    logic [9:0]  nextAddr;

    assign accept   = bus.in_valid && bus.in_ready;
`ifdef ILLEGAL_OP_TRAP_EN
    assign trapHit  = accept && (kind == KIND_NOP);
`else
    assign trapHit  = 1'b0;
`endif
    assign writeNow = accept && !trapHit;
    assign lastAddr = (nextAddr == 10'd1023);

    assign bus.mem_wr_en = wrEn;
    assign bus.mem_addr  = addrReg;
    assign bus.mem_data  = dataReg;
    assign stateDbg      = state;

    // Opcode table lookup and word assembly; R-type repeats the code in 31:26.
    always_comb begin
        code = 6'h00;
        kind = KIND_NOP;
        case (bus.op)
            4'd0:    begin code = 6'h09; kind = KIND_I; end // addiu
            4'd1:    begin code = 6'h03; kind = KIND_J; end // jal
            4'd2:    begin code = 6'h21; kind = KIND_R; end // addu
            4'd3:    begin code = 6'h20; kind = KIND_R; end // add
            4'd4:    begin code = 6'h08; kind = KIND_I; end // addi
            4'd5:    begin code = 6'h2A; kind = KIND_R; end // slt
            4'd6:    begin code = 6'h05; kind = KIND_I; end // bne
            4'd7:    begin code = 6'h04; kind = KIND_I; end // beq
            4'd8:    begin code = 6'h08; kind = KIND_R; end // jr
            4'd9:    begin code = 6'h2B; kind = KIND_I; end // sw
            4'd10:   begin code = 6'h23; kind = KIND_I; end // lw
            default: begin code = 6'h00; kind = KIND_NOP; end
        endcase
        case (kind)
            KIND_I:  encWord = {code, bus.rs, bus.rt, bus.imm};
            KIND_R:  encWord = {code, bus.rs, bus.rt, bus.rd, 5'b00000, code};
            KIND_J:  encWord = {code, bus.target};
            default: encWord = 32'h0000_0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    // Next-state logic; a final transfer beats a coincident finish.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (start) stateNext = LOAD;
            LOAD: begin
                if (trapHit || (writeNow && lastAddr)) stateNext = FULL;
                else if (finish)                       stateNext = DRAIN;
            end
            DRAIN: if (!wrEn) stateNext = IDLE;
            FULL:  if (finish) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM outputs: ready only while loading and the output slot frees up.
    always_comb begin
        bus.in_ready = (state == LOAD) && (!wrEn || bus.mem_ready);
        busy         = (state == LOAD) || (state == DRAIN);
    end

    // Output register: load on an accepted write, empty when memory takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrEn    <= 1'b0;
            addrReg <= 10'd0;
            dataReg <= 32'd0;
        end else if (writeNow) begin
            wrEn    <= 1'b1;
            addrReg <= nextAddr;
            dataReg <= encWord;
        end else if (wrEn && bus.mem_ready) begin
            wrEn    <= 1'b0;
        end
    end

    // Session bookkeeping: address pointer, word count and sticky full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nextAddr   <= 10'd0;
            word_count <= 11'd0;
            full       <= 1'b0;
        end else if ((state == IDLE) && start) begin
            nextAddr   <= base_addr;
            word_count <= 11'd0;
            full       <= 1'b0;
        end else begin
            if (writeNow) begin
                nextAddr   <= nextAddr + 10'd1;
                word_count <= word_count + 11'd1;
            end
            if (trapHit || (writeNow && lastAddr)) full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader: hand-computed instruction
// words, handshake timing, address exhaustion, illegal op and reset behaviour.
module tb_instruction_encoder_loader;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic        finish;
    logic        busy;
    logic        full;
    logic [10:0] word_count;
    logic [1:0]  stateDbg;

    int errors;
    int checks;

    instruction_encoder_loader_if bus ();

    instruction_encoder_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .finish     (finish),
        .bus        (bus),
        .busy       (busy),
        .full       (full),
        .word_count (word_count),
        .stateDbg   (stateDbg)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        bus.op     = o;
        bus.rs     = s;
        bus.rt     = t;
        bus.rd     = d;
        bus.imm    = i;
        bus.target = tg;
    endtask

    task automatic do_start(input logic [9:0] a);
        base_addr = a;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || stateDbg !== S_IDLE) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s: timeout, busy=%b state=%0d, required busy=0 state=IDLE", name, busy, stateDbg);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus.in_ready, bus.mem_wr_en, busy, full} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {bus.in_ready, bus.mem_wr_en, busy, full});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_data, word_count, stateDbg} !== {10'd0, 32'd0, 11'd0, S_IDLE}) begin
            errors++;
            $display("FAIL reset_values: addr=%0d data=%h count=%0d state=%0d required all 0",
                     bus.mem_addr, bus.mem_data, word_count, stateDbg);
        end
        reset_n = 1'b1;
        step();
        // finish while idle must be ignored
        do_finish();
        checks++;
        if ({stateDbg, bus.in_ready} !== {S_IDLE, 1'b0}) begin
            errors++;
            $display("FAIL finish_in_idle: state=%0d in_ready=%b required state=0 in_ready=0", stateDbg, bus.in_ready);
        end
    endtask

    task automatic test_i_type();
        bus.mem_ready = 1'b1;
        do_start(10'd0);
        set_fields(4'd4, 5'd2, 5'd7, 5'd0, 16'h000F, 26'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_data} !== {1'b1, 10'd0, 32'h2047000F}) begin
            errors++;
            $display("FAIL addi_word: wr=%b addr=%0d data=%h required wr=1 addr=0 data=2047000f",
                     bus.mem_wr_en, bus.mem_addr, bus.mem_data);
        end
        step();
        checks++;
        if ({bus.mem_wr_en, word_count} !== {1'b0, 11'd1}) begin
            errors++;
            $display("FAIL addi_drain: wr=%b count=%0d required wr=0 count=1", bus.mem_wr_en, word_count);
        end
        do_finish();
        wait_idle("addi_idle");
    endtask

    task automatic test_back_to_back();
        bus.mem_ready = 1'b1;
        do_start(10'd0);
        checks++;
        if (word_count !== 11'd0) begin
            errors++;
            $display("FAIL start_clears_count: got %0d required 0", word_count);
        end
        set_fields(4'd10, 5'd2, 5'd7, 5'd0, 16'h000F, 26'd0);
        bus.in_valid = 1'b1;
        step();
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_data} !== {1'b1, 10'd0, 32'h8C47000F}) begin
            errors++;
            $display("FAIL lw_word: wr=%b addr=%0d data=%h required wr=1 addr=0 data=8c47000f",
                     bus.mem_wr_en, bus.mem_addr, bus.mem_data);
        end
        set_fields(4'd1, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010);
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count} !== {1'b1, 10'd1, 32'h0C000010, 11'd2}) begin
            errors++;
            $display("FAIL jal_word: wr=%b addr=%0d data=%h count=%0d required wr=1 addr=1 data=0c000010 count=2",
                     bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count);
        end
        step();
        do_finish();
        wait_idle("b2b_idle");
    endtask

    task automatic test_backpressure();
        bus.mem_ready = 1'b0;
        do_start(10'd5);
        set_fields(4'd3, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        bus.in_valid = 1'b1;
        step();
        // next field set (addiu rs=0 rt=0 imm=1) waits behind the stalled word
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 16'h0001, 26'd0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.in_ready, bus.mem_wr_en, bus.mem_addr, bus.mem_data} !== {1'b0, 1'b1, 10'd5, 32'h80221820}) begin
                errors++;
                $display("FAIL add_stall%0d: rdy=%b wr=%b addr=%0d data=%h required rdy=0 wr=1 addr=5 data=80221820",
                         c, bus.in_ready, bus.mem_wr_en, bus.mem_addr, bus.mem_data);
            end
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pass_through_ready: got %b required 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count} !== {1'b1, 10'd6, 32'h24000001, 11'd2}) begin
            errors++;
            $display("FAIL addiu_after_stall: wr=%b addr=%0d data=%h count=%0d required wr=1 addr=6 data=24000001 count=2",
                     bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count);
        end
        step();
        do_finish();
        wait_idle("stall_idle");
    endtask

    task automatic test_finish_same_edge();
        bus.mem_ready = 1'b0;
        do_start(10'd40);
        set_fields(4'd7, 5'd3, 5'd4, 5'd0, 16'hFFFF, 26'd0);
        bus.in_valid = 1'b1;
        finish = 1'b1;
        step();
        bus.in_valid = 1'b0;
        finish = 1'b0;
        // start during DRAIN must not restart the session
        start = 1'b1;
        base_addr = 10'd0;
        checks++;
        if ({stateDbg, bus.in_ready, bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count} !==
            {S_DRAIN, 1'b0, 1'b1, 10'd40, 32'h1064FFFF, 11'd1}) begin
            errors++;
            $display("FAIL finish_with_transfer: state=%0d rdy=%b wr=%b addr=%0d data=%h count=%0d required state=2 rdy=0 wr=1 addr=40 data=1064ffff count=1",
                     stateDbg, bus.in_ready, bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count);
        end
        step();
        start = 1'b0;
        checks++;
        if ({stateDbg, busy, word_count} !== {S_DRAIN, 1'b1, 11'd1}) begin
            errors++;
            $display("FAIL drain_holds: state=%0d busy=%b count=%0d required state=2 busy=1 count=1", stateDbg, busy, word_count);
        end
        bus.mem_ready = 1'b1;
        wait_idle("drain_idle");
    endtask

    task automatic test_full();
        bus.mem_ready = 1'b1;
        do_start(10'd1022);
        set_fields(4'd9, 5'd1, 5'd2, 5'd0, 16'h0010, 26'd0);
        bus.in_valid = 1'b1;
        step();
        checks++;
        if ({bus.mem_addr, bus.mem_data, full, bus.in_ready} !== {10'd1022, 32'hAC220010, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL full_first: addr=%0d data=%h full=%b rdy=%b required addr=1022 data=ac220010 full=0 rdy=1",
                     bus.mem_addr, bus.mem_data, full, bus.in_ready);
        end
        step();
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, full, stateDbg, bus.in_ready} !== {1'b1, 10'd1023, 1'b1, S_FULL, 1'b0}) begin
            errors++;
            $display("FAIL full_last: wr=%b addr=%0d full=%b state=%0d rdy=%b required wr=1 addr=1023 full=1 state=3 rdy=0",
                     bus.mem_wr_en, bus.mem_addr, full, stateDbg, bus.in_ready);
        end
        step();
        checks++;
        if ({bus.mem_wr_en, word_count, bus.in_ready} !== {1'b0, 11'd2, 1'b0}) begin
            errors++;
            $display("FAIL full_third_refused: wr=%b count=%0d rdy=%b required wr=0 count=2 rdy=0",
                     bus.mem_wr_en, word_count, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        do_start(10'd0);
        checks++;
        if ({stateDbg, full} !== {S_FULL, 1'b1}) begin
            errors++;
            $display("FAIL start_in_full: state=%0d full=%b required state=3 full=1", stateDbg, full);
        end
        do_finish();
        checks++;
        if ({stateDbg, full} !== {S_IDLE, 1'b1}) begin
            errors++;
            $display("FAIL full_exit: state=%0d full=%b required state=0 full=1", stateDbg, full);
        end
    endtask

    task automatic test_illegal();
        bus.mem_ready = 1'b1;
        do_start(10'd100);
        checks++;
        if ({full, stateDbg} !== {1'b0, S_LOAD}) begin
            errors++;
            $display("FAIL start_clears_full: full=%b state=%0d required full=0 state=1", full, stateDbg);
        end
        set_fields(4'd12, 5'd5, 5'd6, 5'd7, 16'h1234, 26'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        checks++;
        if ({bus.mem_wr_en, full, stateDbg, word_count} !== {1'b0, 1'b1, S_FULL, 11'd0}) begin
            errors++;
            $display("FAIL illegal_trap: wr=%b full=%b state=%0d count=%0d required wr=0 full=1 state=3 count=0",
                     bus.mem_wr_en, full, stateDbg, word_count);
        end
        do_finish();
`else
        checks++;
        if ({bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count, full} !== {1'b1, 10'd100, 32'h0, 11'd1, 1'b0}) begin
            errors++;
            $display("FAIL illegal_nop: wr=%b addr=%0d data=%h count=%0d full=%b required wr=1 addr=100 data=00000000 count=1 full=0",
                     bus.mem_wr_en, bus.mem_addr, bus.mem_data, word_count, full);
        end
        step();
        do_finish();
`endif
        wait_idle("illegal_idle");
    endtask

    task automatic test_reset_mid_write();
        int writes;
        bus.mem_ready = 1'b0;
        do_start(10'd0);
        set_fields(4'd4, 5'd2, 5'd7, 5'd0, 16'h000F, 26'd0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.mem_wr_en, busy, full, bus.mem_addr, bus.mem_data, word_count} !==
            {4'b0000, 10'd0, 32'd0, 11'd0}) begin
            errors++;
            $display("FAIL async_reset: rdy=%b wr=%b busy=%b full=%b addr=%0d data=%h count=%0d required all 0",
                     bus.in_ready, bus.mem_wr_en, busy, full, bus.mem_addr, bus.mem_data, word_count);
        end
        step();
        reset_n = 1'b1;
        bus.mem_ready = 1'b1;
        writes = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.mem_wr_en === 1'b1) writes++;
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL no_write_after_reset: got %0d writes required 0", writes);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        finish        = 1'b0;
        base_addr     = 10'd0;
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b0;
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);

        test_reset();
        test_i_type();
        test_back_to_back();
        test_backpressure();
        test_finish_same_edge();
        test_full();
        test_illegal();
        test_reset_mid_write();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_encoder_loader.md
INSTRUCTION_ENCODER_LOADER -- requirements
Module: instruction_encoder_loader

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; arms a load session at base_addr.
REQ-004 base_addr  input  10  first instruction-memory word address of the session.
REQ-005 finish  input  1  one-cycle pulse; ends the session after pending writes drain.
REQ-006 in_valid / in_ready  input / output  1 / 1  field-set handshake; a transfer occurs when both are high on a clock edge.
REQ-007 op  input  4  mnemonic select: 0 addiu, 1 jal, 2 addu, 3 add, 4 addi, 5 slt, 6 bne, 7 beq, 8 jr, 9 sw, 10 lw; 11-15 illegal.
REQ-008 rs, rt, rd  input  5 each  register fields.
REQ-009 imm  input  16  I-type immediate.
REQ-010 target  input  26  jal target.
REQ-011 mem_wr_en  output  1  instruction-memory write request.
REQ-012 mem_addr  output  10  write word address.
REQ-013 mem_data  output  32  encoded instruction word.
REQ-014 mem_ready  input  1  memory accepts the write on an edge where mem_wr_en is high.
REQ-015 busy  output  1  high in LOAD or DRAIN.
REQ-016 full  output  1  sticky; address space exhausted.
REQ-017 word_count  output  11  words written in the current session.

Function
REQ-018 Code table (6 bits): addiu 0x09, jal 0x03, addu 0x21, add 0x20, addi 0x08, slt 0x2A, bne 0x05, beq 0x04, jr 0x08, sw 0x2B, lw 0x23.
REQ-019 I-type (addiu, addi, bne, beq, sw, lw) word SHALL be {code, rs, rt, imm}.
REQ-020 R-type (addu, add, slt, jr) word SHALL be {code, rs, rt, rd, 5'b0, code}; bits 31:26 carry the code so the team instruction decoder recognises it.
REQ-021 jal word SHALL be {0x03, target}.
REQ-022 FSM states: IDLE, LOAD, DRAIN, FULL.
REQ-023 IDLE -> LOAD on start; in IDLE, in_ready=0 and inputs are ignored.
REQ-024 LOAD: in_ready = !mem_wr_en || mem_ready (single output register, pass-through ready).
REQ-025 Accepted field set at edge N SHALL present mem_wr_en=1, mem_data, and mem_addr at cycle N+1, held stable until mem_ready is sampled high.
REQ-026 mem_addr starts at base_addr and increments by 1 after each accepted write; word_count increments on the same edge.
REQ-027 LOAD -> DRAIN on finish; in DRAIN, in_ready=0; DRAIN -> IDLE once the output register is empty.
REQ-028 A write accepted at address 1023 SHALL set full and move to FULL; no wrap-around; in_ready=0 in FULL.
REQ-029 FULL -> IDLE on finish; start is ignored in FULL.
REQ-030 start in LOAD or DRAIN is ignored; finish in IDLE is ignored.
REQ-031 If finish and an in_valid transfer occur on the same edge, the transfer is accepted and then DRAIN is entered.
REQ-032 start in IDLE SHALL clear word_count and full.

Reset
REQ-033 While reset_n=0: state=IDLE, in_ready=0, mem_wr_en=0, mem_addr=0, mem_data=0, busy=0, full=0, word_count=0.
REQ-034 Reset mid-write SHALL drop the pending word with no further mem_wr_en.

Configuration
REQ-035 Macro ILLEGAL_OP_TRAP_EN, defined: an illegal op is accepted and not written, and the block enters FULL with full=1 as an error stop.
REQ-036 Macro ILLEGAL_OP_TRAP_EN, undefined: an illegal op is encoded as 32'h00000000 (nop) and written normally.

Verification
REQ-037 start with base_addr=0, then addi rs=2 rt=7 imm=0x000F -> mem_data=0x2047000F at mem_addr=0 one cycle after acceptance.
REQ-038 lw rs=2 rt=7 imm=0x000F, then jal target=0x0000010 with mem_ready=1 -> 0x8C47000F at address 0, then 0x0C000010 at address 1; word_count=2.
REQ-039 add rs=1 rt=2 rd=3 with mem_ready held 0 for 3 cycles -> 0x80221820 held stable, in_ready=0 until mem_ready rises.
REQ-040 start with base_addr=1022, then 3 transfers -> writes at 1022 and 1023, full=1, third transfer not accepted (in_ready=0).
REQ-041 op=12 -> with ILLEGAL_OP_TRAP_EN: no write and full=1; without it: 0x00000000 is written.
REQ-042 reset_n low while mem_wr_en=1 -> all outputs at reset values immediately; no write after release.
